// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmit and device receive paths.
// Holds the transmitter state encoding, default timing constants and the parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_t;

  // 100 us and 15 ms at a 50 MHz system clock
  localparam int PS2_INHIBIT_CYCLES = 5000;
  localparam int PS2_TIMEOUT_CYCLES = 750000;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock and data pins, plus a one-cycle clock falling-edge strobe.
// Latency: pin to sync output 2 cycles, pin to clk_fall 3 cycles; no backpressure.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic clk_pin,
  input  logic data_pin,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_dly;
  logic       fall_q;

  // Reset to the idle bus level (both lines pulled high) so release does not fake an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_ff  <= 2'b11;
      data_ff <= 2'b11;
      clk_dly <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      clk_ff  <= {clk_ff[0], clk_pin};
      data_ff <= {data_ff[0], data_pin};
      clk_dly <= clk_ff[1];
      fall_q  <= clk_dly & ~clk_ff[1];
    end
  end

  assign clk_sync  = clk_ff[1];
  assign data_sync = data_ff[1];
  assign clk_fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, RTS, 8 data, odd parity, stop, ACK); open-drain via OEs.
// tx_ready only in IDLE; OE updates 1 cycle after the fall strobe. Timeout abort built with PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_ack,
  output logic       tx_err
);

  // Inhibit and timeout never overlap, so one counter sized for the longer interval serves both
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  ps2_tx_state_t state, state_nxt;
  logic          clk_sync, data_sync, fall;
  logic [7:0]    shreg;
  logic          par;
  logic [2:0]    bit_cnt;
  logic [CW-1:0] cnt;
  logic          handshake, inh_done, tmo_hit;

  ps2_sync_edge u_sync (
    .clk       (clk),
    .reset     (reset),
    .clk_pin   (ps2_clk_in),
    .data_pin  (ps2_data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (fall)
  );

  assign tx_ready  = (state == ST_IDLE);
  assign handshake = tx_valid & tx_ready;
  assign inh_done  = (state == ST_INHIBIT) && (cnt == CW'(INHIBIT_CYCLES - 1));

`ifdef PS2_HOST_TX_TIMEOUT_EN
  assign tmo_hit = (state != ST_IDLE) && (state != ST_INHIBIT) && (cnt == CW'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    tx_done   = 1'b0;
    tx_err    = 1'b0;
    case (state)
      ST_IDLE:      if (tx_valid) state_nxt = ST_INHIBIT;
      ST_INHIBIT:   if (inh_done) state_nxt = ST_RTS;
      ST_RTS:       if (fall) state_nxt = ST_DATA;
      ST_DATA:      if (fall && bit_cnt == 3'd7) state_nxt = ST_PARITY;
      ST_PARITY:    if (fall) state_nxt = ST_STOP;
      ST_STOP:      if (fall) state_nxt = ST_ACK;
      ST_ACK:       if (fall) state_nxt = ST_WAIT_IDLE;
      ST_WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          tx_done   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default:      state_nxt = ST_IDLE;
    endcase
    if (tmo_hit) begin
      tx_done   = 1'b0;
      tx_err    = 1'b1;
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      par         <= 1'b0;
      bit_cnt     <= '0;
      cnt         <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ack      <= 1'b0;
    end else begin
      state <= state_nxt;

      if (handshake || inh_done) cnt <= '0;
      else if (state == ST_INHIBIT) cnt <= cnt + 1'b1;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      else if (state != ST_IDLE) cnt <= fall ? '0 : cnt + 1'b1;
`endif

      case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            shreg      <= tx_data;
            par        <= odd_parity(tx_data);
            bit_cnt    <= '0;
            tx_ack     <= 1'b0;
            ps2_clk_oe <= 1'b1;
          end
        end
        ST_INHIBIT: begin
          if (inh_done) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
          end
        end
        // The first device fall after RTS already carries bit 0; the start bit went out with RTS
        ST_RTS, ST_DATA: begin
          if (fall) begin
            ps2_data_oe <= ~shreg[0];
            shreg       <= shreg >> 1;
            bit_cnt     <= bit_cnt + 1'b1;
          end
        end
        ST_PARITY: if (fall) ps2_data_oe <= ~par;
        ST_STOP:   if (fall) ps2_data_oe <= 1'b0;
        ST_ACK:    if (fall) tx_ack <= ~data_sync;
        default: ;
      endcase

      if (tmo_hit) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND bus and a simple PS/2 device model.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 200;
  localparam int H   = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_ack, tx_err;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_pin, ps2_data_pin;

  int n_cmp = 0;
  int n_bad = 0;

  assign ps2_clk_pin  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_pin = ~ps2_data_oe & dev_data;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_pin),
    .ps2_data_in (ps2_data_pin),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_done     (tx_done),
    .tx_ack      (tx_ack),
    .tx_err      (tx_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  // Device: waits for RTS, then clocks nclk pulses; samples host data on each rising edge
  task automatic device_run(input int nclk, input logic give_ack, output logic [9:0] bits);
    int n;
    n    = 0;
    bits = '0;
    while (!(ps2_clk_pin && !ps2_data_pin) && n < 1000) begin
      tick();
      n++;
    end
    check_eq("rts_seen", 32'(ps2_clk_pin && !ps2_data_pin), 32'd1);
    repeat (H) tick();
    for (int i = 0; i < nclk; i++) begin
      dev_clk = 1'b0;
      repeat (H) tick();
      dev_clk = 1'b1;
      if (i < 10) bits[i] = ps2_data_pin;
      if (i == 10) begin
        dev_data = 1'b1;
      end else begin
        repeat (H / 2) tick();
        if (i == 9 && give_ack) dev_data = 1'b0;
        repeat (H / 2) tick();
      end
    end
  endtask

  task automatic finish_xfer(input string tag, input logic exp_ack);
    int n;
    n = 0;
    while (!tx_done && !tx_err && n < 500) begin
      tick();
      n++;
    end
    check_eq({tag, "_done"}, 32'(tx_done), 32'd1);
    check_eq({tag, "_ack"}, 32'(tx_ack), 32'(exp_ack));
    check_eq({tag, "_ready_in_pulse"}, 32'(tx_ready), 32'd0);
    tick();
    check_eq({tag, "_ready_after"}, 32'(tx_ready), 32'd1);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] b, input logic give_ack,
                            input logic [9:0] exp_frame);
    logic [9:0] bits;
    request(b);
    device_run(11, give_ack, bits);
    check_eq({tag, "_frame"}, 32'(bits), 32'(exp_frame));
    finish_xfer(tag, give_ack);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         n;
    logic       err_seen;
    logic [9:0] bits;

    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_eq("rst_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check_eq("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check_eq("rst_done", 32'(tx_done), 32'd0);
    check_eq("rst_ack", 32'(tx_ack), 32'd0);
    check_eq("rst_err", 32'(tx_err), 32'd0);

    // 0xED with timing detail: frame LSB first 1,0,1,1,0,1,1,1 then parity 1, stop 1
    request(8'hED);
    check_eq("inh_clk_oe", 32'(ps2_clk_oe), 32'd1);
    check_eq("inh_data_oe", 32'(ps2_data_oe), 32'd0);
    check_eq("inh_ready", 32'(tx_ready), 32'd0);
    n = 0;
    while (ps2_clk_oe && n < 1000) begin
      tick();
      n++;
    end
    check_eq("inh_len", 32'(n), 32'(INH));
    check_eq("rts_data_oe", 32'(ps2_data_oe), 32'd1);
    device_run(11, 1'b1, bits);
    check_eq("ed_frame", 32'(bits), 32'h3ED);
    finish_xfer("ed", 1'b1);

    send_frame("f4", 8'hF4, 1'b1, 10'h2F4);
    send_frame("zero", 8'h00, 1'b1, 10'h300);
    send_frame("noack", 8'h55, 1'b0, 10'h355);

`ifdef PS2_HOST_TX_TIMEOUT_EN
    request(8'hA0);
    n = 0;
    while (ps2_clk_oe && n < 1000) begin
      tick();
      n++;
    end
    n = 0;
    while (!tx_err && n < 1000) begin
      tick();
      n++;
    end
    check_eq("tmo_cycles", 32'(n), 32'(TMO));
    check_eq("tmo_no_done", 32'(tx_done), 32'd0);
    tick();
    check_eq("tmo_ready", 32'(tx_ready), 32'd1);
    check_eq("tmo_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check_eq("tmo_data_oe", 32'(ps2_data_oe), 32'd0);
`else
    request(8'hA0);
    n = 0;
    while (ps2_clk_oe && n < 1000) begin
      tick();
      n++;
    end
    err_seen = 1'b0;
    repeat (TMO + 100) begin
      tick();
      if (tx_err) err_seen = 1'b1;
    end
    check_eq("notmo_err", 32'(err_seen), 32'd0);
    check_eq("notmo_still_rts", 32'(ps2_data_oe), 32'd1);
    check_eq("notmo_busy", 32'(tx_ready), 32'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
`endif

    // Reset during DATA: bits of 0x00 hold data low, so the release is visible
    request(8'h00);
    device_run(4, 1'b0, bits);
    check_eq("mid_data_oe", 32'(ps2_data_oe), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("arst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check_eq("arst_data_oe", 32'(ps2_data_oe), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check_eq("arst_ready", 32'(tx_ready), 32'd1);
    send_frame("post_rst", 8'hF4, 1'b1, 10'h2F4);

    // tx_valid held high; tx_data changed after the first handshake
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    tick();
    check_eq("hv_first_hs", 32'(ps2_clk_oe), 32'd1);
    tx_data = 8'hC3;
    device_run(11, 1'b1, bits);
    check_eq("hv_frame1", 32'(bits), 32'h33C);
    n = 0;
    while (!tx_done && n < 500) begin
      tick();
      n++;
    end
    check_eq("hv_done1", 32'(tx_done), 32'd1);
    check_eq("hv_ready_in_pulse", 32'(tx_ready), 32'd0);
    tick();
    check_eq("hv_idle_ready", 32'(tx_ready), 32'd1);
    check_eq("hv_no_early_hs", 32'(ps2_clk_oe), 32'd0);
    tick();
    check_eq("hv_second_hs", 32'(ps2_clk_oe), 32'd1);
    tx_valid = 1'b0;
    device_run(11, 1'b1, bits);
    check_eq("hv_frame2", 32'(bits), 32'h3C3);
    finish_xfer("hv2", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
